adc_readout_arbiter: RTL and testbench
======================================

// Module: adc_readout_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single PS readout AXIS among the ADC driver outputs.
//  Replaces select-driven static muxing: enabled channels with data are granted in turn.
//  Every grant moves one fixed-length packet of BURST_LEN beats, tagged with channel id.
//  Stalled or disabled channels are padded to full length so the PS never hangs on tlast.
// PARAMETERS
//  N_CH       16   number of ADC driver inputs (2..16)
//  DATA_W     128  beat width (ps_axis_width)
//  BURST_LEN  64   beats per packet (>=2)
//  TIMEOUT    255  max consecutive stall cycles inside a burst before padding
// PORTS
//  clk            in   1             PL clock
//  rst            in   1             reset; asynchronous, active-low
//  enable_mask    in   N_CH          channels eligible for grant (from channel_select)
//  s_axis_tdata   in   N_CH*DATA_W   packed driver data, ch i at [i*DATA_W+:DATA_W]
//  s_axis_tvalid  in   N_CH          per-channel valid
//  s_axis_tready  out  N_CH          per-channel ready (one-hot or zero)
//  m_axis_tdata   out  DATA_W        to PS
//  m_axis_tvalid  out  1
//  m_axis_tready  in   1
//  m_axis_tlast   out  1             high on beat BURST_LEN-1 of each packet
//  m_axis_tuser   out  5             [3:0] channel id, [4] beat is padding
//  busy           out  1             FSM not in IDLE
//  pad_err        out  1             sticky: any packet padded since reset
// BEHAVIOUR
//  Reset (rst=0): state IDLE, all outputs 0, rr pointer=0, counters 0; a burst in flight is discarded.
//  FSM IDLE: eligible = enable_mask & s_axis_tvalid; if nonzero, grant first eligible
//   at or after rr pointer (wrapping at N_CH-1->0), register grant/id, go BURST. No grant -> stay.
//  BURST: s_axis_tready[g] = (!m_axis_tvalid | m_axis_tready); other tready bits 0.
//   Accepted beat loads output register next cycle (latency 1); tuser[4]=0.
//   beat_cnt increments per accepted beat; tlast set when beat_cnt==BURST_LEN-1.
//   stall_cnt counts cycles with tvalid[g]=0 while output slot free; clears on accepted beat.
//   stall_cnt==TIMEOUT or enable_mask[g] falls -> go PAD (tready[g]=0 from that cycle).
//   Last beat accepted -> rr pointer=g+1 (wrap), go IDLE.
//  PAD: emit zero-data beats, tuser[4]=1, same id, until beat_cnt reaches BURST_LEN
//   (tlast on final); set pad_err; rr pointer=g+1; go IDLE.
//  Output register: holds data while m_axis_tvalid & !m_axis_tready; tvalid never drops
//   without handshake. Throughput 1 beat/cycle in BURST; 1 idle cycle between packets.
//  Simultaneous: tvalid[g] and enable fall same cycle -> PAD (enable wins). Mask changes
//   only affect IDLE choice and the granted channel; enabling a bit mid-burst has no effect.
//  Beat accepted on the same cycle stall_cnt reaches TIMEOUT -> beat counts, no PAD.
//  pad_err clears only on reset. beat_cnt width clog2(BURST_LEN), stall_cnt clog2(TIMEOUT+1).
// TESTING
//  1 mask=0x0005, ch0/ch2 always valid, tready=1 -> packets alternate id 0,2,0,2; 64 beats each, tlast beat 63.
//  2 mask=0xFFFF, only ch15 then ch0 valid, rr ptr at 15 -> grant 15, then wraps to 0.
//  3 ch3 granted, tvalid drops after beat 10 for 256 cycles -> 53 pad beats (tuser[4]=1), tlast, pad_err=1.
//  4 ch1 granted, enable_mask[1] cleared at beat 20 -> beats 20..63 zero-padded, next grant other channel.
//  5 random m_axis_tready backpressure 50% -> data/order intact, no tvalid drop w/o handshake, no dup.
//  6 rst asserted mid-burst at beat 30 -> outputs 0 immediately, restart from rr=0, fresh 64-beat packet.

Source files
------------

// File: rtl/adc_readout_arbiter_if.sv
// rtl/adc_readout_arbiter_if.sv - driver-side and PS-side AXIS bundle for the readout arbiter
interface adc_readout_arbiter_if #(
  parameter int N_CH   = 16,
  parameter int DATA_W = 128
);
  logic [N_CH*DATA_W-1:0] s_axis_tdata;
  logic [N_CH-1:0]        s_axis_tvalid;
  logic [N_CH-1:0]        s_axis_tready;
  logic [DATA_W-1:0]      m_axis_tdata;
  logic                   m_axis_tvalid;
  logic                   m_axis_tready;
  logic                   m_axis_tlast;
  logic [4:0]             m_axis_tuser;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
  );
endinterface

// File: rtl/adc_readout_arbiter.sv
// rtl/adc_readout_arbiter.sv - round-robin packet arbiter from ADC drivers onto one PS AXIS
module adc_readout_arbiter #(
  parameter int N_CH      = 16,
  parameter int DATA_W    = 128,
  parameter int BURST_LEN = 64,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      enable_mask,
  adc_readout_arbiter_if.slave axis,
  output logic                 busy,
  output logic                 pad_err
);
  localparam int ID_W = $clog2(N_CH);
  localparam int BW   = $clog2(BURST_LEN);
  localparam int SW   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BURST, PAD} state_t;

  state_t            state, state_nx;
  logic [ID_W-1:0]   grant, grant_nx, rr, rr_nx, pick, grant_wrap;
  logic [BW-1:0]     beat_cnt, beat_nx;
  logic [SW-1:0]     stall_cnt, stall_nx;
  logic              pad_err_nx, pick_found;
  logic [N_CH-1:0]   eligible, s_ready;
  int                idx;

  logic              load, load_last, load_pad;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid, out_last;
  logic [4:0]        out_user;

  logic              slot_free, sel_valid, last_beat;
  logic [DATA_W-1:0] sel_data;

  assign slot_free  = !out_valid || axis.m_axis_tready;
  assign eligible   = enable_mask & axis.s_axis_tvalid;
  assign sel_valid  = axis.s_axis_tvalid[grant];
  assign sel_data   = axis.s_axis_tdata[int'(grant)*DATA_W +: DATA_W];
  assign last_beat  = (beat_cnt == BW'(BURST_LEN - 1));
  assign grant_wrap = (grant == ID_W'(N_CH - 1)) ? '0 : grant + 1'b1;

  // Scan downwards so the closest eligible channel at/after rr is the last one written.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    idx        = 0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx = (int'(rr) + k) % N_CH;
      if (eligible[ID_W'(idx)]) begin
        pick       = ID_W'(idx);
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    grant_nx   = grant;
    rr_nx      = rr;
    beat_nx    = beat_cnt;
    stall_nx   = stall_cnt;
    pad_err_nx = pad_err;
    s_ready    = '0;
    load       = 1'b0;
    load_last  = 1'b0;
    load_pad   = 1'b0;
    load_data  = '0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_nx = pick;
          beat_nx  = '0;
          stall_nx = '0;
          state_nx = BURST;
        end
      end
      BURST: begin
        s_ready[grant] = slot_free && enable_mask[grant];
        if (s_ready[grant] && sel_valid) begin
          // An accepted beat wins over a timeout reached in the same cycle.
          load      = 1'b1;
          load_data = sel_data;
          load_last = last_beat;
          stall_nx  = '0;
          if (last_beat) begin
            beat_nx  = '0;
            rr_nx    = grant_wrap;
            state_nx = IDLE;
          end else begin
            beat_nx = beat_cnt + 1'b1;
          end
        end else if (!enable_mask[grant] || stall_cnt == SW'(TIMEOUT)) begin
          pad_err_nx = 1'b1;
          state_nx   = PAD;
        end else if (slot_free) begin
          stall_nx = stall_cnt + 1'b1;
        end
      end
      PAD: begin
        if (slot_free) begin
          load      = 1'b1;
          load_pad  = 1'b1;
          load_last = last_beat;
          if (last_beat) begin
            beat_nx  = '0;
            rr_nx    = grant_wrap;
            state_nx = IDLE;
          end else begin
            beat_nx = beat_cnt + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      grant     <= '0;
      rr        <= '0;
      beat_cnt  <= '0;
      stall_cnt <= '0;
      pad_err   <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_user  <= '0;
    end else begin
      state     <= state_nx;
      grant     <= grant_nx;
      rr        <= rr_nx;
      beat_cnt  <= beat_nx;
      stall_cnt <= stall_nx;
      pad_err   <= pad_err_nx;
      if (load) begin
        out_data  <= load_data;
        out_valid <= 1'b1;
        out_last  <= load_last;
        out_user  <= {load_pad, 4'(grant)};
      end else if (axis.m_axis_tready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  assign axis.s_axis_tready = s_ready;
  assign axis.m_axis_tdata  = out_data;
  assign axis.m_axis_tvalid = out_valid;
  assign axis.m_axis_tlast  = out_last;
  assign axis.m_axis_tuser  = out_user;
  assign busy               = (state != IDLE);
endmodule

// File: tb/tb_adc_readout_arbiter.sv
// tb/tb_adc_readout_arbiter.sv - randomized bench for adc_readout_arbiter against a packet-level model
module tb_adc_readout_arbiter;
  localparam int N  = 16;
  localparam int W  = 128;
  localparam int BL = 64;
  localparam int TO = 255;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] enable_mask = '0;
  logic         busy, pad_err;

  adc_readout_arbiter_if #(.N_CH(N), .DATA_W(W)) bus ();

  adc_readout_arbiter #(.N_CH(N), .DATA_W(W), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst_n),
    .enable_mask (enable_mask),
    .axis        (bus),
    .busy        (busy),
    .pad_err     (pad_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
    logic [4:0]   user;
    int           stamp;
  } beat_t;

  beat_t        out_q[$];
  logic [W-1:0] exp_q[N][$];
  logic [W-1:0] src_data[N];
  bit           consumed[N];
  int           src_left[N];
  int           gap_left[N];
  int           acc_cnt[N];
  logic [N-1:0] src_en;
  int           valid_pct, rdy_pct, kill_ch, kill_at;
  int           cyc, viol;
  bit           prev_hold;
  logic [W-1:0] prev_data;
  int           vectors = 0;
  int           miscompares = 0;

  function automatic logic [W-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Round-robin rule: first enabled+valid channel at or after the pointer, modulo N.
  function automatic int model_next(int ptr, logic [N-1:0] elig);
    for (int k = 0; k < N; k++)
      if (elig[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic step();
    bit    v;
    beat_t b;
    @(negedge clk);
    if (kill_ch >= 0 && acc_cnt[kill_ch] == kill_at) enable_mask[kill_ch] = 1'b0;
    for (int c = 0; c < N; c++) begin
      if (consumed[c]) begin
        src_data[c] = rnd_word();
        consumed[c] = 1'b0;
      end
      v = 1'b0;
      if (src_en[c]) begin
        if (src_left[c] == 0) begin
          if (gap_left[c] > 0) begin
            gap_left[c]--;
            if (gap_left[c] == 0) src_left[c] = -1;
          end
        end else begin
          v = ($urandom_range(99) < valid_pct);
        end
      end
      bus.s_axis_tvalid[c]          = v;
      bus.s_axis_tdata[c*W +: W]    = src_data[c];
    end
    bus.m_axis_tready = ($urandom_range(99) < rdy_pct);
    #1;
    if (prev_hold && (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== prev_data)) viol++;
    if ($countones(bus.s_axis_tready) > 1) viol++;
    prev_hold = bus.m_axis_tvalid && !bus.m_axis_tready;
    prev_data = bus.m_axis_tdata;
    for (int c = 0; c < N; c++) begin
      if (bus.s_axis_tvalid[c] && bus.s_axis_tready[c]) begin
        exp_q[c].push_back(src_data[c]);
        consumed[c] = 1'b1;
        acc_cnt[c]++;
        if (src_left[c] > 0) src_left[c]--;
      end
    end
    if (bus.m_axis_tvalid && bus.m_axis_tready) begin
      b.data  = bus.m_axis_tdata;
      b.last  = bus.m_axis_tlast;
      b.user  = bus.m_axis_tuser;
      b.stamp = cyc;
      out_q.push_back(b);
    end
    cyc++;
  endtask

  task automatic clear_model();
    out_q.delete();
    for (int c = 0; c < N; c++) begin
      exp_q[c].delete();
      consumed[c] = 1'b1;
      src_left[c] = -1;
      gap_left[c] = 0;
      acc_cnt[c]  = 0;
    end
    prev_hold = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n             = 1'b0;
    enable_mask       = '0;
    src_en            = '0;
    bus.s_axis_tvalid = '0;
    bus.s_axis_tdata  = '0;
    bus.m_axis_tready = 1'b0;
    valid_pct = 100;
    rdy_pct   = 100;
    kill_ch   = -1;
    kill_at   = 0;
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_beats(input int n, input int budget, output bit timed_out);
    int t = 0;
    while (out_q.size() < n && t < budget) begin
      step();
      t++;
    end
    timed_out = (out_q.size() < n);
  endtask

  // Splits one packet off the observed stream; reports structure problems and data misorder as errs.
  task automatic pop_packet(output int id, output int n_real, output int n_pad, output int errs,
                            output int t_first, output int t_last, output int t_lastreal,
                            output int t_firstpad);
    beat_t b;
    id = -1; n_real = 0; n_pad = 0; errs = 0;
    t_first = -1; t_last = -1; t_lastreal = -1; t_firstpad = -1;
    for (int i = 0; i < BL; i++) begin
      if (out_q.size() == 0) begin
        errs++;
        break;
      end
      b = out_q.pop_front();
      if (i == 0) begin
        id      = int'(b.user[3:0]);
        t_first = b.stamp;
      end else if (int'(b.user[3:0]) != id) begin
        errs++;
      end
      if (b.last !== (i == BL - 1)) errs++;
      if (b.user[4]) begin
        if (n_pad == 0) t_firstpad = b.stamp;
        n_pad++;
        if (b.data !== '0) errs++;
      end else begin
        if (n_pad != 0) errs++;
        n_real++;
        t_lastreal = b.stamp;
        if (exp_q[id].size() == 0) errs++;
        else if (exp_q[id].pop_front() !== b.data) errs++;
      end
      t_last = b.stamp;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    vectors++;
    if ({bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tuser, busy, pad_err} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 0", {bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tuser, busy, pad_err});
    end
    vectors++;
    if (bus.m_axis_tdata !== '0 || bus.s_axis_tready !== '0) begin
      miscompares++;
      $display("FAIL reset_data: tdata %h tready %h want 0", bus.m_axis_tdata, bus.s_axis_tready);
    end
    src_en = '1;
    repeat (8) step();
    vectors++;
    if (busy !== 1'b0 || out_q.size() != 0) begin
      miscompares++;
      $display("FAIL mask_zero_idle: busy %b beats %0d want 0 0", busy, out_q.size());
    end
  endtask

  task automatic test_round_robin();
    int id, nr, np, er, tf, tl, tlr, tfp, ptr, g, prev_last;
    bit to;
    apply_reset();
    enable_mask = 16'h0005;
    src_en      = 16'h0005;
    wait_beats(4 * BL, 2000, to);
    vectors++;
    if (to) begin
      miscompares++;
      $display("FAIL rr_timeout: got %0d beats want %0d", out_q.size(), 4 * BL);
    end
    ptr = 0;
    prev_last = -1;
    for (int p = 0; p < 4; p++) begin
      pop_packet(id, nr, np, er, tf, tl, tlr, tfp);
      g = model_next(ptr, 16'h0005);
      vectors++;
      if (id != g || nr != BL || er != 0) begin
        miscompares++;
        $display("FAIL rr_pkt%0d: id %0d real %0d errs %0d want id %0d real %0d errs 0", p, id, nr, er, g, BL);
      end
      if (p > 0) begin
        vectors++;
        if (tf - prev_last != 2) begin
          miscompares++;
          $display("FAIL rr_gap%0d: got %0d cycles want 2", p, tf - prev_last);
        end
      end
      prev_last = tl;
      ptr = (g + 1) % N;
    end
  endtask

  task automatic test_wrap();
    int id, nr, np, er, tf, tl, tlr, tfp, ptr, g;
    bit to;
    apply_reset();
    enable_mask  = 16'hFFFF;
    src_en       = 16'h4000;
    src_left[14] = BL;
    wait_beats(BL, 1000, to);
    pop_packet(id, nr, np, er, tf, tl, tlr, tfp);
    vectors++;
    if (to || id != 14 || nr != BL || er != 0) begin
      miscompares++;
      $display("FAIL wrap_pre: id %0d real %0d errs %0d to %0b want 14 %0d 0 0", id, nr, er, to, BL);
    end
    src_en = 16'h8001;
    wait_beats(3 * BL, 2000, to);
    ptr = 15;
    for (int p = 0; p < 3; p++) begin
      pop_packet(id, nr, np, er, tf, tl, tlr, tfp);
      g = model_next(ptr, 16'h8001);
      vectors++;
      if (to || id != g || nr != BL || er != 0) begin
        miscompares++;
        $display("FAIL wrap_pkt%0d: id %0d real %0d errs %0d want id %0d real %0d", p, id, nr, er, g, BL);
      end
      ptr = (g + 1) % N;
    end
  endtask

  task automatic test_stall_pad();
    int id, nr, np, er, tf, tl, tlr, tfp;
    bit to;
    apply_reset();
    enable_mask = 16'hFFFF;
    src_en      = 16'h0008;
    src_left[3] = 11;
    wait_beats(BL, 1500, to);
    pop_packet(id, nr, np, er, tf, tl, tlr, tfp);
    vectors++;
    if (to || id != 3 || nr != 11 || np != BL - 11 || er != 0) begin
      miscompares++;
      $display("FAIL stall_pad_pkt: id %0d real %0d pad %0d errs %0d want 3 11 %0d 0", id, nr, np, er, BL - 11);
    end
    vectors++;
    if (tfp - tlr < TO + 1 || tfp - tlr > TO + 3) begin
      miscompares++;
      $display("FAIL stall_pad_delay: got %0d cycles want %0d..%0d", tfp - tlr, TO + 1, TO + 3);
    end
    repeat (3) step();
    vectors++;
    if (pad_err !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_pad_flags: pad_err %b busy %b want 1 0", pad_err, busy);
    end
  endtask

  task automatic test_stall_boundary();
    int id, nr, np, er, tf, tl, tlr, tfp;
    bit to;
    apply_reset();
    enable_mask = 16'hFFFF;
    src_en      = 16'h0008;
    src_left[3] = 11;
    gap_left[3] = TO;
    wait_beats(BL, 1500, to);
    pop_packet(id, nr, np, er, tf, tl, tlr, tfp);
    vectors++;
    if (to || id != 3 || nr != BL || np != 0 || er != 0 || pad_err !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_edge: id %0d real %0d pad %0d errs %0d pad_err %b want 3 %0d 0 0 0", id, nr, np, er, pad_err, BL);
    end
  endtask

  task automatic test_disable_pad();
    int id, nr, np, er, tf, tl, tlr, tfp;
    bit to;
    apply_reset();
    enable_mask = 16'h0006;
    src_en      = 16'h0006;
    kill_ch     = 1;
    kill_at     = 20;
    wait_beats(2 * BL, 2000, to);
    pop_packet(id, nr, np, er, tf, tl, tlr, tfp);
    vectors++;
    if (to || id != 1 || nr != 20 || np != BL - 20 || er != 0) begin
      miscompares++;
      $display("FAIL disable_pkt: id %0d real %0d pad %0d errs %0d want 1 20 %0d 0", id, nr, np, er, BL - 20);
    end
    pop_packet(id, nr, np, er, tf, tl, tlr, tfp);
    vectors++;
    if (id != 2 || nr != BL || er != 0 || pad_err !== 1'b1) begin
      miscompares++;
      $display("FAIL disable_next: id %0d real %0d errs %0d pad_err %b want 2 %0d 0 1", id, nr, er, pad_err, BL);
    end
  endtask

  task automatic test_backpressure();
    int id, nr, np, er, tf, tl, tlr, tfp, ptr, g;
    bit to;
    logic [N-1:0] m;
    apply_reset();
    m = N'($urandom_range(1, 16'hFFFF));
    enable_mask = 16'hFFFF;
    src_en      = m;
    rdy_pct     = 50;
    wait_beats(6 * BL, 3000, to);
    ptr = 0;
    for (int p = 0; p < 6; p++) begin
      pop_packet(id, nr, np, er, tf, tl, tlr, tfp);
      g = model_next(ptr, m);
      vectors++;
      if (to || id != g || nr != BL || er != 0) begin
        miscompares++;
        $display("FAIL bp_pkt%0d: mask %h id %0d real %0d errs %0d want id %0d real %0d", p, m, id, nr, er, g, BL);
      end
      ptr = (g + 1) % N;
    end
    valid_pct = 70;
    wait_beats(4 * BL, 3000, to);
    for (int p = 0; p < 4; p++) begin
      pop_packet(id, nr, np, er, tf, tl, tlr, tfp);
      vectors++;
      if (to || id < 0 || m[id[3:0]] !== 1'b1 || nr != BL || er != 0) begin
        miscompares++;
        $display("FAIL bp_rand%0d: mask %h id %0d real %0d errs %0d want enabled id real %0d", p, m, id, nr, er, BL);
      end
    end
    vectors++;
    if (viol != 0) begin
      miscompares++;
      $display("FAIL bp_protocol: got %0d violations want 0", viol);
    end
  endtask

  task automatic test_reset_mid_burst();
    int id, nr, np, er, tf, tl, tlr, tfp, t;
    apply_reset();
    enable_mask = 16'hFFFF;
    src_en      = 16'h0021;
    t = 0;
    while (acc_cnt[5] != 30 && t < 1000) begin
      step();
      t++;
    end
    vectors++;
    if (acc_cnt[5] != 30) begin
      miscompares++;
      $display("FAIL mid_rst_reach: got %0d beats want 30", acc_cnt[5]);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tuser, busy} !== 8'b0 ||
        bus.s_axis_tready !== '0 || bus.m_axis_tdata !== '0) begin
      miscompares++;
      $display("FAIL mid_rst_out: tvalid %b busy %b tready %h tdata %h want 0", bus.m_axis_tvalid, busy, bus.s_axis_tready, bus.m_axis_tdata);
    end
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    wait_beats(BL, 1000, id[0]);
    pop_packet(id, nr, np, er, tf, tl, tlr, tfp);
    vectors++;
    if (id != model_next(0, 16'h0021) || nr != BL || np != 0 || er != 0) begin
      miscompares++;
      $display("FAIL mid_rst_restart: id %0d real %0d pad %0d errs %0d want %0d %0d 0 0", id, nr, np, er, model_next(0, 16'h0021), BL);
    end
  endtask

  initial begin
    cyc  = 0;
    viol = 0;
    test_reset();
    test_round_robin();
    test_wrap();
    test_stall_pad();
    test_stall_boundary();
    test_disable_pad();
    test_backpressure();
    test_reset_mid_burst();
    vectors++;
    if (viol != 0) begin
      miscompares++;
      $display("FAIL protocol_total: got %0d violations want 0", viol);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
